// File: rtl/pc_if_queue.sv
// ---------------------------------------------------------------------------
// pc_if_queue
//
// Decouples the PC stage from the IF stage with a DEPTH-entry circular
// buffer of fetch requests. Each entry holds {is_branch_taken, pht_index, pc}.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// when valid and ready are both high in the cycle before that edge. A push
// offered while push_ready is low, or a pop requested while pop_valid is low,
// has no effect. push_ready and pop_valid come from registered state only,
// so neither one depends combinationally on push_valid or pop_ready.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   flush               discard every entry; wins over push and pop
//   push_valid          PC stage offers a request
//   push_ready          queue has room (not full)
//   is_branch_taken_in  predicted-taken bit of the offered request
//   pht_index_in        PHT index of the offered request
//   pc_in               PC of the offered request
//   pop_ready           IF stage consumes the head
//   pop_valid           head entry is valid (not empty)
//   is_branch_taken_out head predicted-taken bit (0 while empty)
//   pht_index_out       head PHT index (0 while empty)
//   pc_out              head PC (0 while empty)
//   count               current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module pc_if_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 5,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic                  is_branch_taken_in,
    input  logic [GHR_WIDTH-1:0]  pht_index_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  pop_ready,
    output logic                  pop_valid,
    output logic                  is_branch_taken_out,
    output logic [GHR_WIDTH-1:0]  pht_index_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [CNT_W-1:0]      count
);

    localparam int ENTRY_W = 1 + GHR_WIDTH + ADDR_WIDTH;

    logic [ENTRY_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign push_ready = (count != CNT_W'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_ready & pop_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            // Stale entry contents are left in place; the head is masked
            // while empty and every slot is rewritten before it is read.
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[wp] <= {is_branch_taken_in, pht_index_in, pc_in};
                wp          <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Head is forced to zero while empty so downstream never sees stale data.
    assign head = pop_valid ? entries[rp] : '0;
    assign {is_branch_taken_out, pht_index_out, pc_out} = head;

endmodule

// File: tb/tb_pc_if_queue.sv
// ---------------------------------------------------------------------------
// tb_pc_if_queue
//
// Directed bench for pc_if_queue (DEPTH = 4, 32-bit PC, 5-bit PHT index).
// Inputs change 1 ns after each rising edge; outputs are sampled at that
// same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_pc_if_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int GW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic          is_branch_taken_in;
    logic [GW-1:0] pht_index_in;
    logic [AW-1:0] pc_in;
    logic          pop_ready;
    logic          pop_valid;
    logic          is_branch_taken_out;
    logic [GW-1:0] pht_index_out;
    logic [AW-1:0] pc_out;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] exp_pc;

    pc_if_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .GHR_WIDTH  (GW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .push_valid          (push_valid),
        .push_ready          (push_ready),
        .is_branch_taken_in  (is_branch_taken_in),
        .pht_index_in        (pht_index_in),
        .pc_in               (pc_in),
        .pop_ready           (pop_ready),
        .pop_valid           (pop_valid),
        .is_branch_taken_out (is_branch_taken_out),
        .pht_index_out       (pht_index_out),
        .pc_out              (pc_out),
        .count               (count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush              = 1'b0;
        push_valid         = 1'b0;
        pop_ready          = 1'b0;
        is_branch_taken_in = 1'b0;
        pht_index_in       = '0;
        pc_in              = '0;
    endtask

    task automatic push_one(input logic [AW-1:0] pc, input logic tk, input logic [GW-1:0] pht);
        push_valid         = 1'b1;
        pc_in              = pc;
        is_branch_taken_in = tk;
        pht_index_in       = pht;
        step();
        push_valid = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".pop_valid"},  32'(pop_valid),  32'd0);
        check({tag, ".push_ready"}, 32'(push_ready), 32'd1);
        check({tag, ".count"},      32'(count),      32'd0);
        check({tag, ".pc_out"},     pc_out,          32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst = 1'b0;

        // Reset with random activity on every input: nothing may be accepted.
        for (int i = 0; i < 4; i++) begin
            flush              = 1'($urandom_range(0, 1));
            push_valid         = 1'b1;
            pop_ready          = 1'($urandom_range(0, 1));
            is_branch_taken_in = 1'($urandom_range(0, 1));
            pht_index_in       = GW'($urandom_range(0, 31));
            pc_in              = $urandom;
            step();
        end
        check_empty("reset");
        check("reset.taken_out", 32'(is_branch_taken_out), 32'd0);
        check("reset.pht_out",   32'(pht_index_out),       32'd0);
        idle_inputs();
        rst = 1'b1;
        step();
        check_empty("post_reset");

        // Fill to DEPTH with pop_ready low, then try one extra push.
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(32'h100 + 32'(4 * i));
            push_one(32'h100 + 32'(4 * i), 1'b0, '0);
        end
        check("fill.count",      32'(count),      32'd4);
        check("fill.push_ready", 32'(push_ready), 32'd0);
        push_one(32'h110, 1'b0, '0);
        check("fill.reject_count", 32'(count), 32'd4);

        // Drain in order.
        pop_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_pc = exp_q.pop_front();
            check("drain.pop_valid", 32'(pop_valid), 32'd1);
            check("drain.pc_out",    pc_out,         exp_pc);
            step();
        end
        pop_ready = 1'b0;
        check_empty("drained");

        // Sideband integrity.
        push_one(32'h200, 1'b1, 5'h1A);
        push_one(32'h204, 1'b0, 5'h03);
        check("side0.pc",    pc_out,                    32'h200);
        check("side0.taken", 32'(is_branch_taken_out),  32'd1);
        check("side0.pht",   32'(pht_index_out),        32'h1A);
        pop_ready = 1'b1;
        step();
        check("side1.pc",    pc_out,                    32'h204);
        check("side1.taken", 32'(is_branch_taken_out),  32'd0);
        check("side1.pht",   32'(pht_index_out),        32'h03);
        step();
        pop_ready = 1'b0;
        check_empty("side_done");

        // Streaming across pointer wrap: one pre-fill, then push+pop each cycle.
        exp_q.push_back(32'h400);
        push_one(32'h400, 1'b0, '0);
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            pc_in = 32'h404 + 32'(4 * i);
            exp_q.push_back(pc_in);
            exp_pc = exp_q.pop_front();
            check("stream.pop_valid", 32'(pop_valid), 32'd1);
            check("stream.count",     32'(count),     32'd1);
            check("stream.pc_out",    pc_out,         exp_pc);
            step();
        end
        push_valid = 1'b0;
        exp_pc = exp_q.pop_front();
        check("stream.last_pc", pc_out, exp_pc);
        step();
        pop_ready = 1'b0;
        check_empty("stream_done");

        // Full boundary: pop wins, push is rejected that cycle.
        for (int i = 0; i < DEPTH; i++) begin
            push_one(32'h500 + 32'(4 * i), 1'b0, '0);
        end
        push_valid = 1'b1;
        pc_in      = 32'h510;
        pop_ready  = 1'b1;
        check("full.push_ready", 32'(push_ready), 32'd0);
        step();
        check("full.count_after_pop", 32'(count), 32'd3);
        check("full.head_after_pop",  pc_out,     32'h504);
        pop_ready = 1'b0;
        step();
        push_valid = 1'b0;
        check("full.count_refill", 32'(count),      32'd4);
        check("full.ready_refill", 32'(push_ready), 32'd0);

        // Bring occupancy to 3, then flush alongside push and pop.
        pop_ready = 1'b1;
        step();
        check("preflush.count", 32'(count), 32'd3);
        flush      = 1'b1;
        push_valid = 1'b1;
        pc_in      = 32'h600;
        step();
        idle_inputs();
        check_empty("flush");
        push_one(32'h300, 1'b0, '0);
        check("postflush.pop_valid", 32'(pop_valid), 32'd1);
        check("postflush.pc_out",    pc_out,         32'h300);
        check("postflush.count",     32'(count),     32'd1);

        // Pop requested in the same cycle as a push into an empty queue.
        pop_ready = 1'b1;
        step();
        check_empty("pop_only");
        push_valid = 1'b1;
        pc_in      = 32'h700;
        step();
        idle_inputs();
        check("empty_pushpop.count", 32'(count), 32'd1);
        check("empty_pushpop.pc",    pc_out,     32'h700);

        // Asynchronous reset: takes effect without a clock edge.
        push_one(32'h704, 1'b1, 5'h11);
        #2;
        rst = 1'b0;
        #1;
        check_empty("async_reset");
        step();
        rst = 1'b1;
        step();
        check_empty("async_release");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_if_queue.md
# pc_if_queue

Parametrised PC→IF decoupling queue, the next generation of the single-entry PC/IF pipeline register. It buffers up to DEPTH fetch requests between the PC stage and the IF stage. Each request carries its PC, predicted-taken bit and PHT index. Ready/valid handshakes on both sides replace the old stall pair, and a flush empties the whole queue in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- ADDR_WIDTH, `ADDR_BUS_WIDTH`: PC width.
- GHR_WIDTH, `GHR_WIDTH`: PHT index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries; highest priority.
- push_valid  in  1  PC stage offers a request.
- push_ready  out  1  queue can accept (= !full).
- is_branch_taken_in  in  1  predicted-taken bit of the offered request.
- pht_index_in  in  GHR_WIDTH  PHT index of the offered request.
- pc_in  in  ADDR_WIDTH  PC of the offered request.
- pop_ready  in  1  IF stage consumes the head (IF not stalled).
- pop_valid  out  1  head entry valid (= !empty).
- is_branch_taken_out  out  1  head predicted-taken bit.
- pht_index_out  out  GHR_WIDTH  head PHT index.
- pc_out  out  ADDR_WIDTH  head PC.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer with write pointer wp, read pointer rp (log2(DEPTH) bits, natural wrap) and occupancy counter count (0..DEPTH).
- push = push_valid & push_ready; pop = pop_ready & pop_valid. A push with push_ready low is ignored, and so is a pop with pop_valid low.
- Push: write {is_branch_taken_in, pht_index_in, pc_in} to entry[wp]; wp+1.
- Pop: rp+1.
- count next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- push_ready = (count != DEPTH). pop_valid = (count != 0). Both depend on registered state only, so there is no combinational path from pop_ready to push_ready.
- Head outputs are entry[rp] when pop_valid = 1. When pop_valid = 0 they are forced to 0.
- Full + push_valid + pop_ready: the pop happens and the push is rejected (push_ready = 0 that cycle). count becomes DEPTH−1.
- Empty + push_valid + pop_ready: only the push happens; the new entry appears on the next cycle.
- Flush: wp = rp = count = 0 at the next edge. A push or pop in the same cycle is discarded. Entry contents need not be cleared, because outputs are masked while empty.
- Reset: wp = rp = count = 0 and all entries 0, applied asynchronously on rst low.
- Reset outputs: push_ready = 1, pop_valid = 0, all data outputs 0, count = 0.
- Release of rst is synchronous to clk; the first push is accepted on the first edge with rst high.

## Timing
- Latency: data pushed at edge N is on the head outputs after edge N if the queue was empty. Zero-cycle bypass does not exist.
- Throughput: one push and one pop per cycle, sustained, when 0 < count < DEPTH.
- push_ready, pop_valid and count all change only on clk edges or on asynchronous reset.
- Flush in cycle N: pop_valid = 0 and push_ready = 1 from edge N+1 onward.
- Pointer wrap: after DEPTH pushes and DEPTH pops, wp and rp return to 0 with no bubble.

## Test plan
- Reset: hold rst = 0 with random inputs → push_ready = 1, pop_valid = 0, pc_out = 0, count = 0; no entry written.
- Fill/drain, DEPTH = 4, pop_ready = 0: push PCs 0x100, 0x104, 0x108, 0x10C → count = 4 and push_ready = 0; a fifth push of 0x110 is rejected. Then pop_ready = 1 → pc_out shows 0x100, 0x104, 0x108, 0x10C on successive cycles, then pop_valid = 0.
- Sideband integrity: push (pc = 0x200, taken = 1, pht = 5'h1A) then (0x204, 0, 5'h03) → the same tuples pop out in order.
- Streaming wrap: push and pop every cycle for 3·DEPTH cycles after one pre-fill → count stays at 1, PCs come out in order across pointer wrap, no bubbles.
- Full boundary: count = 4 with push_valid = 1 and pop_ready = 1 → head pops, push is rejected, count = 3. Next cycle the push is accepted and count = 4.
- Flush: with count = 3, assert flush together with push_valid and pop_ready → next cycle count = 0, pop_valid = 0, push_ready = 1. A later push of 0x300 is the first PC seen at the head.
